// File: rtl/edge_frame_sequencer_if.sv
// Video-input / line-buffer-control bundle of the edge-detection frame sequencer.
// The EDGE_SEQ_STATS_EN build adds the frame statistics outputs.
interface edge_frame_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int ROW_W  = 9
);
    logic              I_PIX_VLD;
    logic              I_VSYNC;
    logic              I_HSYNC;
    logic              I_DE;
    logic              O_LB_WR_EN;
    logic [ADDR_W-1:0] O_LB_ADDR;
    logic              O_LB_ROT;
    logic              O_WIN_VLD;
    logic              O_BORDER;
    logic              O_VSYNC;
    logic              O_HSYNC;
    logic              O_DE;
    logic              O_FRAME_ERR;
    logic [1:0]        O_STATE;
`ifdef EDGE_SEQ_STATS_EN
    logic [15:0]       O_FRAME_CNT;
    logic [ADDR_W-1:0] O_MEAS_W;
    logic [ROW_W-1:0]  O_MEAS_H;

    modport master (
        output I_PIX_VLD, I_VSYNC, I_HSYNC, I_DE,
        input  O_LB_WR_EN, O_LB_ADDR, O_LB_ROT, O_WIN_VLD, O_BORDER,
        input  O_VSYNC, O_HSYNC, O_DE, O_FRAME_ERR, O_STATE,
        input  O_FRAME_CNT, O_MEAS_W, O_MEAS_H
    );
    modport slave (
        input  I_PIX_VLD, I_VSYNC, I_HSYNC, I_DE,
        output O_LB_WR_EN, O_LB_ADDR, O_LB_ROT, O_WIN_VLD, O_BORDER,
        output O_VSYNC, O_HSYNC, O_DE, O_FRAME_ERR, O_STATE,
        output O_FRAME_CNT, O_MEAS_W, O_MEAS_H
    );
`else
    modport master (
        output I_PIX_VLD, I_VSYNC, I_HSYNC, I_DE,
        input  O_LB_WR_EN, O_LB_ADDR, O_LB_ROT, O_WIN_VLD, O_BORDER,
        input  O_VSYNC, O_HSYNC, O_DE, O_FRAME_ERR, O_STATE
    );
    modport slave (
        input  I_PIX_VLD, I_VSYNC, I_HSYNC, I_DE,
        output O_LB_WR_EN, O_LB_ADDR, O_LB_ROT, O_WIN_VLD, O_BORDER,
        output O_VSYNC, O_HSYNC, O_DE, O_FRAME_ERR, O_STATE
    );
`endif
endinterface

// File: rtl/edge_frame_sequencer.sv
// Frame/line sequencer for the Sobel datapath: pixel counters, line-buffer control, window/border
// flags and sync delay line. Optional frame statistics are enabled with `define EDGE_SEQ_STATS_EN.
module edge_frame_sequencer #(
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480,
    parameter int ADDR_W     = 10,
    parameter int ROW_W      = 9,
    parameter int PIPE_LAT   = 3
) (
    input logic                   I_CORE_CLK,
    input logic                   I_RST,
    edge_frame_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        VBLANK     = 2'd1,
        LINE       = 2'd2,
        HBLANK     = 2'd3
    } state_t;

    typedef struct packed {
        logic              vs;
        logic              hs;
        logic              de;
        logic [ROW_W-1:0]  row;
        logic [ADDR_W-1:0] col;
    } tap_t;

    localparam logic [ADDR_W-1:0] MAX_W_C    = ADDR_W'(MAX_WIDTH);
    localparam logic [ROW_W-1:0]  MAX_H_C    = ROW_W'(MAX_HEIGHT);
    localparam logic [ROW_W-1:0]  LAST_ROW_C = ROW_W'(MAX_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] COL_TWO_C  = ADDR_W'(2);
    localparam logic [ROW_W-1:0]  ROW_TWO_C  = ROW_W'(2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] ref_w_q, ref_w_d;
    logic              ref_vld_q, ref_vld_d;
    logic              err_q, err_d;
    logic              vsync_q;
    logic [ROW_W-1:0]  last_h_q;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              win_q, win_d;
    logic              rot_q, rot_d;
    logic [ROW_W-1:0]  pix_row;
    logic [ADDR_W-1:0] pix_col;
    logic              frame_end;
    tap_t              smp_q, smp_d;
    tap_t              dly_q [PIPE_LAT];
    tap_t              out_tap;

    logic strobe, vs_rise, col_ovf, row_ovf, width_bad, line_vs_err, err_now;

    assign strobe      = bus.I_PIX_VLD;
    assign vs_rise     = bus.I_VSYNC & ~vsync_q;
    assign col_ovf     = (state_q == LINE) && bus.I_DE && (col_q >= MAX_W_C);
    assign row_ovf     = (state_q == HBLANK) && bus.I_DE && !vs_rise && (row_q >= MAX_H_C);
    assign width_bad   = (state_q == LINE) && !bus.I_DE && ref_vld_q && (col_q != ref_w_q);
    assign line_vs_err = (state_q == LINE) && vs_rise;
    assign err_now     = strobe && (col_ovf || row_ovf || width_bad || line_vs_err);

    always_ff @(posedge I_CORE_CLK) begin
        if (I_RST) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    // Line/frame tracking; counters stop where the error fired, so they never wrap.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        ref_w_d   = ref_w_q;
        ref_vld_d = ref_vld_q;
        err_d     = err_q;
        frame_end = 1'b0;
        if (strobe) begin
            if (err_now) begin
                state_d = WAIT_FRAME;
                err_d   = 1'b1;
            end else begin
                case (state_q)
                    WAIT_FRAME: begin
                        if (vs_rise) begin
                            state_d   = VBLANK;
                            row_d     = '0;
                            col_d     = '0;
                            ref_w_d   = '0;
                            ref_vld_d = 1'b0;
                        end
                    end
                    VBLANK: begin
                        if (bus.I_DE) begin
                            state_d = LINE;
                            row_d   = '0;
                            col_d   = ADDR_W'(1);
                        end
                    end
                    LINE: begin
                        if (bus.I_DE) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            state_d = HBLANK;
                            row_d   = row_q + 1'b1;
                            if (!ref_vld_q) begin
                                ref_w_d   = col_q;
                                ref_vld_d = 1'b1;
                            end
                        end
                    end
                    HBLANK: begin
                        if (vs_rise) begin
                            state_d   = VBLANK;
                            frame_end = 1'b1;
                            row_d     = '0;
                            col_d     = '0;
                            ref_w_d   = '0;
                            ref_vld_d = 1'b0;
                        end else if (bus.I_DE) begin
                            state_d = LINE;
                            col_d   = ADDR_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // The first DE strobe of a line is written at column 0 while the FSM is still in a blank state.
    always_comb begin
        wr_d    = 1'b0;
        addr_d  = addr_q;
        win_d   = 1'b0;
        rot_d   = 1'b0;
        pix_row = (state_q == VBLANK) ? '0 : row_q;
        pix_col = (state_q == LINE) ? col_q : '0;
        if (strobe && !err_now) begin
            if (bus.I_DE && ((state_q == LINE) || (state_q == VBLANK) ||
                             ((state_q == HBLANK) && !vs_rise))) begin
                wr_d   = 1'b1;
                addr_d = pix_col;
                win_d  = (pix_row >= ROW_TWO_C) && (pix_col >= COL_TWO_C);
            end
            if ((state_q == LINE) && !bus.I_DE) begin
                rot_d = 1'b1;
            end
        end
    end

    assign smp_d = '{vs: bus.I_VSYNC, hs: bus.I_HSYNC, de: bus.I_DE, row: pix_row, col: pix_col};

    always_ff @(posedge I_CORE_CLK) begin
        if (I_RST) begin
            col_q     <= '0;
            row_q     <= '0;
            ref_w_q   <= '0;
            ref_vld_q <= 1'b0;
            err_q     <= 1'b0;
            vsync_q   <= 1'b0;
            last_h_q  <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            win_q     <= 1'b0;
            rot_q     <= 1'b0;
            smp_q     <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            ref_w_q   <= ref_w_d;
            ref_vld_q <= ref_vld_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            win_q     <= win_d;
            rot_q     <= rot_d;
            if (strobe) begin
                vsync_q  <= bus.I_VSYNC;
                smp_q    <= smp_d;
                dly_q[0] <= smp_q;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
                if (frame_end) begin
                    last_h_q <= row_q;
                end
            end
        end
    end

    // The last row of the frame in flight is predicted from the previous frame's height.
    assign out_tap = dly_q[PIPE_LAT-1];

    assign bus.O_BORDER = out_tap.de &&
                          ((out_tap.row == '0) || (out_tap.col == '0) ||
                           (ref_vld_q && (out_tap.col == ref_w_q - 1'b1)) ||
                           (out_tap.row == LAST_ROW_C) ||
                           ((last_h_q != '0) && (out_tap.row == last_h_q - 1'b1)));

    assign bus.O_LB_WR_EN  = wr_q;
    assign bus.O_LB_ADDR   = addr_q;
    assign bus.O_LB_ROT    = rot_q;
    assign bus.O_WIN_VLD   = win_q;
    assign bus.O_VSYNC     = out_tap.vs;
    assign bus.O_HSYNC     = out_tap.hs;
    assign bus.O_DE        = out_tap.de;
    assign bus.O_FRAME_ERR = err_q;
    assign bus.O_STATE     = state_q;

`ifdef EDGE_SEQ_STATS_EN
    logic [15:0]       frame_cnt_q;
    logic [ADDR_W-1:0] meas_w_q;
    logic [ROW_W-1:0]  meas_h_q;

    always_ff @(posedge I_CORE_CLK) begin
        if (I_RST) begin
            frame_cnt_q <= '0;
            meas_w_q    <= '0;
            meas_h_q    <= '0;
        end else if (strobe && frame_end) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            meas_w_q    <= ref_w_q;
            meas_h_q    <= row_q;
        end
    end

    assign bus.O_FRAME_CNT = frame_cnt_q;
    assign bus.O_MEAS_W    = meas_w_q;
    assign bus.O_MEAS_H    = meas_h_q;
`endif
endmodule
